// File: rtl/rseq_pkg.sv
// ---------------------------------------------------------------------------
// rseq_pkg
// Shared definitions for the reset sequencer: the FSM state encoding and the
// default delay constants used as parameter defaults by reset_sequencer.
//
// Configuration macro: RSEQ_CAM_PWDN_EN
//   defined   -> the PWDN_WAIT state exists in the encoding
//   undefined -> PWDN_WAIT is absent
// ---------------------------------------------------------------------------
package rseq_pkg;

  localparam int unsigned DEF_LOCK_STABLE_CYC = 16;
  localparam int unsigned DEF_CAM_DELAY_CYC   = 8;
  localparam int unsigned DEF_PWDN_DELAY_CYC  = 4;
  localparam int unsigned DEF_CNT_W           = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    CORE_REL  = 3'd1,
`ifdef RSEQ_CAM_PWDN_EN
    PWDN_WAIT = 3'd2,
`endif
    CAM_WAIT  = 3'd3,
    RUN       = 3'd4
  } rseq_state_e;

endpackage : rseq_pkg

// File: rtl/rseq_lock_sync.sv
// ---------------------------------------------------------------------------
// rseq_lock_sync
// Two-flop synchronizer that brings the asynchronous PLL/DCM lock indication
// into the clk domain. Both flops clear on synchronous reset, so a lock that
// is already high at reset release still takes two edges to appear on q.
//
// Ports:
//   clk   - sampling clock
//   reset - synchronous, active-high reset
//   d     - asynchronous input
//   q     - synchronized output (second flop)
// ---------------------------------------------------------------------------
module rseq_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : rseq_lock_sync

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Power-up reset sequencer for a camera design. Waits for LOCK_STABLE_CYC
// consecutive cycles of synchronized PLL lock, releases core reset, (option-
// ally powers the sensor up and waits PWDN_DELAY_CYC,) waits CAM_DELAY_CYC,
// then releases the camera reset and reports seq_done. Losing lock after it
// was qualified drops everything back into reset and sets a sticky flag.
//
// Configuration macro: RSEQ_CAM_PWDN_EN
//   defined   -> cam_pwdn port and PWDN_WAIT state present
//   undefined -> no cam_pwdn port, PWDN_DELAY_CYC ignored
//
// Ports:
//   clk         - single clock, all logic on the rising edge
//   reset       - synchronous, active-high reset
//   pll_lock    - asynchronous PLL/DCM lock, active-high
//   clear_err   - synchronous pulse that clears lock_lost
//   core_reset  - active-high reset for core logic
//   cam_reset_n - active-low camera sensor reset
//   seq_done    - sequence complete, all domains running
//   lock_lost   - sticky lock-loss flag
//   cam_pwdn    - camera power-down, active-high (macro only)
// ---------------------------------------------------------------------------
module reset_sequencer
  import rseq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int unsigned CAM_DELAY_CYC   = DEF_CAM_DELAY_CYC,
  parameter int unsigned PWDN_DELAY_CYC  = DEF_PWDN_DELAY_CYC,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic clear_err,
  output logic core_reset,
  output logic cam_reset_n,
  output logic seq_done,
  output logic lock_lost
`ifdef RSEQ_CAM_PWDN_EN
  ,
  output logic cam_pwdn
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_STABLE_CYC);
  localparam logic [CNT_W-1:0] CAM_TGT  = CNT_W'(CAM_DELAY_CYC);
`ifdef RSEQ_CAM_PWDN_EN
  localparam logic [CNT_W-1:0] PWDN_TGT = CNT_W'(PWDN_DELAY_CYC);
`else
  // The power-down delay has no meaning without the power-down state; it is
  // folded into a dead signal so the parameter stays part of the interface.
  logic unused_pwdn_delay;
  assign unused_pwdn_delay = ^(CNT_W'(PWDN_DELAY_CYC));
`endif

  rseq_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             lock_s;
  logic             lock_lost_q;
  logic             loss_event;

  rseq_lock_sync u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Saturating increment: the shared counter never wraps back to zero.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // Lock loss only counts once lock has been qualified (any state past
  // WAIT_LOCK); a dropout during qualification just restarts the count.
  assign loss_event = (state != WAIT_LOCK) && !lock_s;

  // State and counter registers plus the sticky lock-loss flag. A new loss
  // wins over a simultaneous clear so an event is never silently dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (loss_event) begin
        lock_lost_q <= 1'b1;
      end else if (clear_err) begin
        lock_lost_q <= 1'b0;
      end
    end
  end

  // Next-state logic. The counter is reloaded to zero on every state entry;
  // a transition fires on the cycle the incremented count reaches its target.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_next = '0;
        end else if (cnt_inc == LOCK_TGT) begin
          state_next = CORE_REL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      CORE_REL: begin
`ifdef RSEQ_CAM_PWDN_EN
        state_next = PWDN_WAIT;
`else
        state_next = CAM_WAIT;
`endif
        cnt_next = '0;
      end
`ifdef RSEQ_CAM_PWDN_EN
      PWDN_WAIT: begin
        if (cnt_inc == PWDN_TGT) begin
          state_next = CAM_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
`endif
      CAM_WAIT: begin
        if (cnt_inc == CAM_TGT) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      RUN: begin
        cnt_next = '0;
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
    if (loss_event) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
    end
  end

  // Output decode. On a loss event the outputs fall back to their reset
  // values in the same cycle the synchronized lock drops, one edge before
  // the state register itself returns to WAIT_LOCK.
  always_comb begin
    core_reset  = 1'b1;
    cam_reset_n = 1'b0;
    seq_done    = 1'b0;
`ifdef RSEQ_CAM_PWDN_EN
    cam_pwdn    = 1'b1;
`endif
    if (!loss_event) begin
      case (state)
        CORE_REL: begin
          core_reset = 1'b0;
        end
`ifdef RSEQ_CAM_PWDN_EN
        PWDN_WAIT: begin
          core_reset = 1'b0;
          cam_pwdn   = 1'b0;
        end
`endif
        CAM_WAIT: begin
          core_reset = 1'b0;
`ifdef RSEQ_CAM_PWDN_EN
          cam_pwdn   = 1'b0;
`endif
        end
        RUN: begin
          core_reset  = 1'b0;
          cam_reset_n = 1'b1;
          seq_done    = 1'b1;
`ifdef RSEQ_CAM_PWDN_EN
          cam_pwdn    = 1'b0;
`endif
        end
        default: begin
          core_reset = 1'b1;
        end
      endcase
    end
  end

  assign lock_lost = lock_lost_q | loss_event;

endmodule : reset_sequencer
